// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX stage: default widths, the decoded
// control-bit bundle and its bubble encoding.
package id_ex_stage_pkg;

  localparam int XLEN_DEFAULT           = 32;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;
  localparam int CNT_WIDTH_DEFAULT      = 16;
  localparam int CTRL_WIDTH             = 6;
  localparam int NUM_EVENT_CNT          = 2;

  // Bit order, MSB first: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch}
  typedef struct packed {
    logic alu_src;
    logic memto_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Event counter slots
  localparam int CNT_STALL = 0;
  localparam int CNT_FLUSH = 1;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard comparator: a load sitting in EX whose destination is read
// by the instruction in ID forces a one-cycle stall.
module id_ex_stage_hazard_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  output logic                      hazard_stall
);

  logic rd_nonzero;
  logic rs_match;

  assign rd_nonzero = (ex_rd != '0);
  // rs2 is compared regardless of instruction format; a spurious stall is
  // cheaper than decoding the format here.
  assign rs_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);

  assign hazard_stall = ex_valid & ex_mem_read & rd_nonzero & id_valid & rs_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion on
// stall or EX flush, and saturating stall/flush event counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_ALUSrc,
  input  logic                      id_MemtoReg,
  input  logic                      id_RegWrite,
  input  logic                      id_MemRead,
  input  logic                      id_MemWrite,
  input  logic                      id_Branch,
  input  logic [XLEN-1:0]           id_pc,
  input  logic [XLEN-1:0]           id_rs1_data,
  input  logic [XLEN-1:0]           id_rs2_data,
  input  logic [XLEN-1:0]           id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [3:0]                id_funct,
  input  logic                      ex_flush,
  output logic                      hazard_stall,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      ex_valid,
  output logic                      ex_ALUSrc,
  output logic                      ex_MemtoReg,
  output logic                      ex_RegWrite,
  output logic                      ex_MemRead,
  output logic                      ex_MemWrite,
  output logic                      ex_Branch,
  output logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           ex_rs1_data,
  output logic [XLEN-1:0]           ex_rs2_data,
  output logic [XLEN-1:0]           ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [3:0]                ex_funct,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  ctrl_t                      id_ctrl;
  logic                       insert_bubble;

  logic                       ex_valid_reg,  ex_valid_next;
  ctrl_t                      ex_ctrl_reg,   ex_ctrl_next;
  logic [XLEN-1:0]            ex_pc_reg,     ex_pc_next;
  logic [XLEN-1:0]            ex_rs1_data_reg, ex_rs1_data_next;
  logic [XLEN-1:0]            ex_rs2_data_reg, ex_rs2_data_next;
  logic [XLEN-1:0]            ex_imm_reg,    ex_imm_next;
  logic [REG_ADDR_WIDTH-1:0]  ex_rs1_reg,    ex_rs1_next;
  logic [REG_ADDR_WIDTH-1:0]  ex_rs2_reg,    ex_rs2_next;
  logic [REG_ADDR_WIDTH-1:0]  ex_rd_reg,     ex_rd_next;
  logic [3:0]                 ex_funct_reg,  ex_funct_next;

  logic [NUM_EVENT_CNT-1:0]   cnt_event;
  logic [CNT_WIDTH-1:0]       cnt_reg [NUM_EVENT_CNT];

  assign id_ctrl = {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch};

  id_ex_stage_hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .ex_valid     (ex_valid_reg),
    .ex_mem_read  (ex_ctrl_reg.mem_read),
    .ex_rd        (ex_rd_reg),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .hazard_stall (hazard_stall)
  );

  // During a flush the PC mux takes the branch redirect over pc_write, so the
  // stall is allowed to keep pc_write low in that cycle.
  assign pc_write      = ~hazard_stall;
  assign if_id_write   = ~hazard_stall;
  assign insert_bubble = ex_flush | hazard_stall;

  always_comb begin
    ex_valid_next    = 1'b0;
    ex_ctrl_next     = CTRL_BUBBLE;
    ex_pc_next       = '0;
    ex_rs1_data_next = '0;
    ex_rs2_data_next = '0;
    ex_imm_next      = '0;
    ex_rs1_next      = '0;
    ex_rs2_next      = '0;
    ex_rd_next       = '0;
    ex_funct_next    = '0;
    if (!insert_bubble) begin
      ex_valid_next    = id_valid;
      ex_ctrl_next     = id_valid ? id_ctrl : CTRL_BUBBLE;
      ex_pc_next       = id_pc;
      ex_rs1_data_next = id_rs1_data;
      ex_rs2_data_next = id_rs2_data;
      ex_imm_next      = id_imm;
      ex_rs1_next      = id_rs1;
      ex_rs2_next      = id_rs2;
      ex_rd_next       = id_rd;
      ex_funct_next    = id_funct;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg    <= 1'b0;
      ex_ctrl_reg     <= CTRL_BUBBLE;
      ex_pc_reg       <= '0;
      ex_rs1_data_reg <= '0;
      ex_rs2_data_reg <= '0;
      ex_imm_reg      <= '0;
      ex_rs1_reg      <= '0;
      ex_rs2_reg      <= '0;
      ex_rd_reg       <= '0;
      ex_funct_reg    <= '0;
    end else begin
      ex_valid_reg    <= ex_valid_next;
      ex_ctrl_reg     <= ex_ctrl_next;
      ex_pc_reg       <= ex_pc_next;
      ex_rs1_data_reg <= ex_rs1_data_next;
      ex_rs2_data_reg <= ex_rs2_data_next;
      ex_imm_reg      <= ex_imm_next;
      ex_rs1_reg      <= ex_rs1_next;
      ex_rs2_reg      <= ex_rs2_next;
      ex_rd_reg       <= ex_rd_next;
      ex_funct_reg    <= ex_funct_next;
    end
  end

  // A stall that coincides with a flush is not a stall: the flush bubble wins.
  assign cnt_event[CNT_STALL] = hazard_stall & ~ex_flush;
  assign cnt_event[CNT_FLUSH] = ex_flush;

  generate
    for (genvar gi = 0; gi < NUM_EVENT_CNT; gi++) begin : g_event_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_event[gi] && (cnt_reg[gi] != '1)) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  assign stall_count = cnt_reg[CNT_STALL];
  assign flush_count = cnt_reg[CNT_FLUSH];

  assign ex_valid    = ex_valid_reg;
  assign ex_ALUSrc   = ex_ctrl_reg.alu_src;
  assign ex_MemtoReg = ex_ctrl_reg.memto_reg;
  assign ex_RegWrite = ex_ctrl_reg.reg_write;
  assign ex_MemRead  = ex_ctrl_reg.mem_read;
  assign ex_MemWrite = ex_ctrl_reg.mem_write;
  assign ex_Branch   = ex_ctrl_reg.branch;
  assign ex_pc       = ex_pc_reg;
  assign ex_rs1_data = ex_rs1_data_reg;
  assign ex_rs2_data = ex_rs2_data_reg;
  assign ex_imm      = ex_imm_reg;
  assign ex_rs1      = ex_rs1_reg;
  assign ex_rs2      = ex_rs2_reg;
  assign ex_rd       = ex_rd_reg;
  assign ex_funct    = ex_funct_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic against a
// behavioural model; a second instance with 4-bit counters checks saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic        ex_flush;

  wire         hazard_stall, pc_write, if_id_write, ex_valid;
  wire         ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
  wire  [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  wire  [4:0]  ex_rs1, ex_rs2, ex_rd;
  wire  [3:0]  ex_funct;
  wire  [15:0] stall_count, flush_count;

  wire         s_hazard_stall, s_pc_write, s_if_id_write, s_ex_valid;
  wire         s_ALUSrc, s_MemtoReg, s_RegWrite, s_MemRead, s_MemWrite, s_Branch;
  wire  [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  wire  [4:0]  s_rs1, s_rs2, s_rd;
  wire  [3:0]  s_funct;
  wire  [3:0]  s_stall_count, s_flush_count;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ALUSrc(id_ctrl[5]), .id_MemtoReg(id_ctrl[4]), .id_RegWrite(id_ctrl[3]),
    .id_MemRead(id_ctrl[2]), .id_MemWrite(id_ctrl[1]), .id_Branch(id_ctrl[0]),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .ex_flush(ex_flush), .hazard_stall(hazard_stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .ex_valid(ex_valid),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  id_ex_stage #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ALUSrc(id_ctrl[5]), .id_MemtoReg(id_ctrl[4]), .id_RegWrite(id_ctrl[3]),
    .id_MemRead(id_ctrl[2]), .id_MemWrite(id_ctrl[1]), .id_Branch(id_ctrl[0]),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .ex_flush(ex_flush), .hazard_stall(s_hazard_stall), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .ex_valid(s_ex_valid),
    .ex_ALUSrc(s_ALUSrc), .ex_MemtoReg(s_MemtoReg), .ex_RegWrite(s_RegWrite),
    .ex_MemRead(s_MemRead), .ex_MemWrite(s_MemWrite), .ex_Branch(s_Branch),
    .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model of the EX slot; ctrl bits {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch}
  bit          m_known = 0;
  bit          m_valid;
  bit [5:0]    m_ctrl;
  bit [31:0]   m_pc, m_rs1_data, m_rs2_data, m_imm;
  bit [4:0]    m_rs1, m_rs2, m_rd;
  bit [3:0]    m_funct;
  int unsigned m_stalls, m_flushes, m_stalls4, m_flushes4;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_hazard();
    return m_valid && m_ctrl[2] && (m_rd != 0) && id_valid &&
           ((m_rd == id_rs1) || (m_rd == id_rs2));
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic set_id(input bit v, input bit [5:0] c, input bit [31:0] pc, input bit [31:0] imm,
                        input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
    id_valid    = v;
    id_ctrl     = c;
    id_pc       = pc;
    id_imm      = imm;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_funct    = 4'($urandom);
  endtask

  task automatic do_cycle();
    bit hz;
    #2;
    hz = model_hazard();
    if (m_known) begin
      check_val("hazard_stall", hazard_stall, hz);
      check_val("pc_write", pc_write, !hz);
      check_val("if_id_write", if_id_write, !hz);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs1_data = 0; m_rs2_data = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0;
      m_stalls = 0; m_flushes = 0; m_stalls4 = 0; m_flushes4 = 0;
    end else begin
      if (ex_flush) begin
        m_flushes  = sat_inc(m_flushes, 65535);
        m_flushes4 = sat_inc(m_flushes4, 15);
      end else if (hz) begin
        m_stalls   = sat_inc(m_stalls, 65535);
        m_stalls4  = sat_inc(m_stalls4, 15);
      end
      if (ex_flush || hz) begin
        m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs1_data = 0; m_rs2_data = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0;
      end else begin
        m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : 6'd0;
        m_pc = id_pc; m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data; m_imm = id_imm;
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
      end
    end
    m_known = 1;
    #1;
    check_val("ex_valid", ex_valid, m_valid);
    check_val("ex_ctrl", {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch}, m_ctrl);
    check_val("ex_pc", ex_pc, m_pc);
    check_val("ex_rs1_data", ex_rs1_data, m_rs1_data);
    check_val("ex_rs2_data", ex_rs2_data, m_rs2_data);
    check_val("ex_imm", ex_imm, m_imm);
    check_val("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m_rs1, m_rs2, m_rd});
    check_val("ex_funct", ex_funct, m_funct);
    check_val("stall_count", stall_count, m_stalls);
    check_val("flush_count", flush_count, m_flushes);
    check_val("stall_count4", s_stall_count, m_stalls4);
    check_val("flush_count4", s_flush_count, m_flushes4);
    $display("cyc=%0d rst=%0b flush=%0b hz=%0b ex_valid=%0b ex_rd=%0d stalls=%0d flushes=%0d",
             cyc, rst, ex_flush, hz, ex_valid, ex_rd, stall_count, flush_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every input driven nonzero
    rst = 1; ex_flush = 1;
    set_id(1, 6'b111111, 32'hFFFF_FFF0, 32'h1234_5678, 5'd6, 5'd7, 5'd6);
    do_cycle();
    do_cycle();
    check_val("rst_pc_write", pc_write, 1);
    check_val("rst_flush_count", flush_count, 0);
    rst = 0; ex_flush = 0;

    // addi x5: passthrough
    set_id(1, 6'b101000, 32'h100, 32'h10, 5'd1, 5'd0, 5'd5);
    do_cycle();
    check_val("pass_rd", ex_rd, 5);
    check_val("pass_imm", ex_imm, 32'h10);
    check_val("pass_pc", ex_pc, 32'h100);
    check_val("pass_ctrl", {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch}, 6'b101000);

    // lw x6 then dependent add
    set_id(1, 6'b111100, 32'h104, 32'h0, 5'd2, 5'd3, 5'd6);
    do_cycle();
    set_id(1, 6'b001000, 32'h108, 32'h0, 5'd6, 5'd7, 5'd8);
    #2;
    check_val("lu_stall", hazard_stall, 1);
    check_val("lu_pc_write", pc_write, 0);
    do_cycle();
    check_val("lu_bubble_valid", ex_valid, 0);
    check_val("lu_stall_count", stall_count, 1);
    do_cycle();
    check_val("lu_add_rd", ex_rd, 8);
    check_val("lu_stall_clear", hazard_stall, 0);

    // lw x0 then rs1=0: no stall
    set_id(1, 6'b111100, 32'h10C, 32'h0, 5'd2, 5'd3, 5'd0);
    do_cycle();
    set_id(1, 6'b111100, 32'h110, 32'h0, 5'd0, 5'd0, 5'd7);
    #1;
    check_val("x0_no_stall", hazard_stall, 0);
    do_cycle();
    // lw x7 then rs1=3, rs2=4: no stall
    set_id(1, 6'b111100, 32'h114, 32'h0, 5'd3, 5'd4, 5'd6);
    #1;
    check_val("nodep_no_stall", hazard_stall, 0);
    do_cycle();

    // lw x6 in EX, ID rs2=6, flush in the same cycle
    set_id(1, 6'b001000, 32'h118, 32'h0, 5'd9, 5'd6, 5'd10);
    ex_flush = 1;
    do_cycle();
    ex_flush = 0;
    check_val("fh_flush_count", flush_count, 1);
    check_val("fh_stall_count", stall_count, 1);
    check_val("fh_bubble", ex_valid, 0);

    // Random traffic with small register indices so hazards are frequent
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      ex_flush = ($urandom_range(0, 5) == 0);
      set_id($urandom_range(0, 3) != 0, 6'($urandom), $urandom, $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      do_cycle();
    end

    // Saturation of the 4-bit flush counter
    rst = 1; ex_flush = 0;
    do_cycle();
    rst = 0; ex_flush = 1;
    for (int i = 0; i < 20; i++) begin
      set_id(1, 6'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      do_cycle();
    end
    ex_flush = 0;
    check_val("sat_flush4", s_flush_count, 15);
    check_val("sat_flush16", flush_count, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus load-use hazard detector. Sits directly downstream of the ID control decoder.
- Latches the six decoded control bits, operands and register indices for EX.
- Generates the `stall` fed back to the decoder, and the PC / IF-ID write enables.
- Inserts bubbles on load-use hazards and on EX branch-taken flushes. Keeps saturating stall/flush event counters.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 16, width of the event counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  in  1 each  decoder outputs
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file reads
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register indices
- id_funct  in  4  {inst[30], funct3} for ALU control
- ex_flush  in  1  branch/jump taken, resolved in EX
- hazard_stall  out  1  to decoder `stall`
- pc_write  out  1  PC enable; equals ~hazard_stall
- if_id_write  out  1  IF/ID enable; equals ~hazard_stall
- ex_valid  out  1  EX slot holds a real instruction
- ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1 each  registered control
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered operands
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_WIDTH  registered indices, for forwarding
- ex_funct  out  4  registered funct
- stall_count, flush_count  out  CNT_WIDTH  saturating event counters

Behaviour:
- Reset: every registered output is 0 (valid, control, data, indices, counters). With ex_MemRead=0, hazard_stall=0, so pc_write=if_id_write=1.
- hazard_stall is combinational from registered EX state and current ID inputs: `ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2)`. It is conservative: rs2 is compared even for I-type.
- Each rising edge, priority rst > ex_flush > hazard_stall > normal:
  - ex_flush: load a bubble. ex_valid=0, all six control bits 0, ex_rd=0. Data fields are don't-care; they are cleared to 0.
  - hazard_stall (no flush): load the same bubble. ID/IF are held upstream via pc_write/if_id_write=0, so the instruction is re-presented next cycle.
  - normal: capture all id_* fields; ex_valid=id_valid. If id_valid=0, the control bits are forced to 0.
- Latency: one cycle, ID to EX outputs.
- A load-use hazard costs exactly one bubble. The next cycle's EX holds the bubble (ex_MemRead=0), so the stall self-clears.
- Back-to-back loads each stall once only when dependent.
- Flush with a simultaneous hazard: flush wins. hazard_stall still drives pc_write low that cycle; the EX branch unit owns the PC redirect, so the PC mux gives redirect priority over pc_write.
- Counters:
  - stall_count increments on each edge where hazard_stall=1 and ex_flush=0.
  - flush_count increments on each edge where ex_flush=1.
  - Both saturate at all-ones and never wrap.
  - Both are cleared only by rst.
- Reset mid-stall: rst wins; outputs return to the reset state on the next edge.

Decomposition:
- Shared constants (const.v): XLEN, REG_ADDR_WIDTH, control-bit ordering {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch}, bubble encoding 6'b000000.
- One sub-module: hazard_detect (combinational load-use comparator producing hazard_stall).
- Counters and the pipeline register stay inline.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 and all inputs nonzero -> all ex_* outputs=0, counters=0, pc_write=1.
- Passthrough: addi x5 (ALUSrc=1, RegWrite=1, rd=5, imm=0x10, pc=0x100) -> next edge ex_rd=5, ex_imm=0x10, ex_pc=0x100, control=6'b101000, ex_valid=1.
- Load-use: lw x6 captured into EX (MemRead=1, rd=6), then ID add with rs1=6 -> hazard_stall=1, pc_write=0. The next edge loads a bubble (control=0, ex_valid=0) and stall_count=1. The following edge captures the add; hazard_stall=0.
- No false stall: lw with rd=0 followed by ID rs1=0 -> hazard_stall=0. lw rd=7 followed by rs1=3, rs2=4 -> hazard_stall=0.
- Flush vs hazard: lw rd=6 in EX, ID rs2=6, ex_flush=1 on the same cycle -> bubble loaded, flush_count=1, stall_count unchanged.
- Saturation: force CNT_WIDTH=4, apply 20 flushes -> flush_count=15 and holds.
